// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between one master and the SRAM responder.
// hready is the fabric-level ready that is fed back into the selected slave.
interface ahb_sram_slave_if #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
);
    logic                      hsel;
    logic [AHB_ADDR_WIDTH-1:0] haddr;
    logic [1:0]                htrans;
    logic                      hwrite;
    logic [2:0]                hsize;
    logic [2:0]                hburst;
    logic [3:0]                hprot;
    logic                      hmastlock;
    logic                      hready;
    logic [AHB_DATA_WIDTH-1:0] hwdata;
    logic [AHB_DATA_WIDTH-1:0] hrdata;
    logic                      hreadyout;
    logic                      hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: register-array memory with byte-lane writes,
// programmable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 1024,
    parameter int WAIT_STATES    = 0
) (
    input  logic            hclk,
    input  logic            hreset,
    ahb_sram_slave_if.slave bus
);
    localparam int NUM_LANES = AHB_DATA_WIDTH / 8;
    localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * 4;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]                state, state_nxt;
    logic [3:0]                wcnt, wcnt_nxt;
    logic [AHB_ADDR_WIDTH-1:0] addr_q;
    logic                      write_q;
    logic [2:0]                size_q;
    logic                      err_q;
    logic [NUM_LANES-1:0][7:0] mem [MEM_DEPTH];

    logic                 open_slot, accept, addr_err, commit;
    logic [IDX_W-1:0]     widx;
    logic [NUM_LANES-1:0] be;

    // Only cycles where this slave shows hreadyout=1 can end a data phase and take a new address.
    assign open_slot = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign accept    = open_slot & bus.hsel & bus.hready & bus.htrans[1];
    assign widx      = addr_q[IDX_W+1:2];
    assign commit    = (state == S_DATA) & write_q & ~err_q;

    always_comb begin
        addr_err = 1'b0;
        if (64'(bus.haddr) >= MEM_BYTES)                               addr_err = 1'b1;
        if (bus.hsize > 3'd2)                                          addr_err = 1'b1;
        if ((bus.hsize == 3'd1) && bus.haddr[0])                       addr_err = 1'b1;
        if ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00))          addr_err = 1'b1;
    end

    always_comb begin
        state_nxt = S_IDLE;
        wcnt_nxt  = wcnt;
        case (state)
            S_WAIT: begin
                if (wcnt == 4'd0) begin
                    state_nxt = S_DATA;
                end else begin
                    state_nxt = S_WAIT;
                    wcnt_nxt  = wcnt - 4'd1;
                end
            end
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                if (accept) begin
                    if (addr_err) begin
                        state_nxt = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                        wcnt_nxt  = WAIT_INIT;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (accept) begin
                addr_q  <= bus.haddr;
                write_q <= bus.hwrite;
                size_q  <= bus.hsize;
                err_q   <= addr_err;
            end
        end
    end

    // Little-endian lane strobes; size and alignment were already vetted at accept.
    always_comb begin
        be = '0;
        case (size_q)
            3'd0:    be[addr_q[1:0]] = 1'b1;
            3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = '1;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hreset && commit) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (be[i]) mem[widx][i] <= bus.hwdata[8*i +: 8];
            end
        end
    end

    assign bus.hrdata    = ((state == S_DATA) && !write_q) ? mem[widx] : '0;
    assign bus.hreadyout = !((state == S_WAIT) || (state == S_ERR1));
    assign bus.hresp     = (state == S_ERR1) || (state == S_ERR2);

    logic unused_bits;
    assign unused_bits = ^{bus.hburst, bus.hprot, bus.hmastlock, addr_q};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Three responders (0, 2 and 3 wait states) share one master; the fabric hready is the AND
// of their hreadyouts. A byte-array model predicts each response into a shared scoreboard.
module tb_ahb_sram_slave;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 1024;
    localparam int NDUT = 3;
    localparam int unsigned MEM_BYTES = DEPTH * 4;

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    logic          hsel = 1'b0;
    logic [AW-1:0] haddr = '0;
    logic [1:0]    htrans = 2'b00;
    logic          hwrite = 1'b0;
    logic [2:0]    hsize = 3'd0;
    logic [2:0]    hburst = 3'd0;
    logic [3:0]    hprot = 4'd0;
    logic          hmastlock = 1'b0;
    logic [DW-1:0] hwdata = '0;
    logic          hready;
    logic [NDUT-1:0]         rdy, resp;
    logic [NDUT-1:0][DW-1:0] rdata;

    for (genvar g = 0; g < NDUT; g++) begin : gd
        ahb_sram_slave_if #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW)) bus ();
        assign bus.hsel      = hsel;
        assign bus.haddr     = haddr;
        assign bus.htrans    = htrans;
        assign bus.hwrite    = hwrite;
        assign bus.hsize     = hsize;
        assign bus.hburst    = hburst;
        assign bus.hprot     = hprot;
        assign bus.hmastlock = hmastlock;
        assign bus.hready    = hready;
        assign bus.hwdata    = hwdata;
        assign rdy[g]   = bus.hreadyout;
        assign resp[g]  = bus.hresp;
        assign rdata[g] = bus.hrdata;
        ahb_sram_slave #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                         .WAIT_STATES(g == 0 ? 0 : g + 1))
            dut (.hclk(hclk), .hreset(hreset), .bus(bus.slave));
    end
    assign hready = &rdy;

    function automatic int ws_of(int i);
        return (i == 0) ? 0 : i + 1;
    endfunction

    int nvec = 0;
    int nerr = 0;

    function automatic void chk(input string nm, input int idx, input logic [31:0] act,
                                input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %h want %h", nm, idx, act, exp);
        end
    endfunction

    // Reference model: flat byte memory, errors from the access rules.
    logic [7:0] mb [MEM_BYTES];
    typedef struct packed { logic err; logic [31:0] data; } exp_t;
    exp_t sbq[$];
    int   rd_ptr [NDUT];

    function automatic logic is_err(input logic [31:0] a, input logic [2:0] sz);
        if (a >= MEM_BYTES) return 1'b1;
        if (sz > 3'd2)      return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    function automatic void predict(input logic [31:0] a, input logic w, input logic [2:0] sz,
                                    input logic [31:0] wd);
        exp_t e;
        int   base;
        e.err  = is_err(a, sz);
        e.data = '0;
        if (!e.err) begin
            if (w) begin
                for (int b = 0; b < (1 << sz); b++) mb[a + b] = wd[8 * ((a + b) % 4) +: 8];
            end else begin
                base   = int'(a) & ~3;
                e.data = {mb[base + 3], mb[base + 2], mb[base + 1], mb[base]};
            end
        end
        sbq.push_back(e);
    endfunction

    // One address phase, held until the fabric accepts it; afterwards hwdata carries its data.
    task automatic issue(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic [2:0] sz, input logic [31:0] wd,
                         input bit track = 1'b1);
        logic acc;
        int   n;
        hsel = sel; htrans = tr; haddr = a; hwrite = w; hsize = sz;
        hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
        n = 0;
        do begin
            @(negedge hclk);
            acc = hready;
            @(posedge hclk);
            #1;
            n++;
        end while (!acc && n < 40);
        if (!acc) begin
            nerr++;
            $display("FAIL accept_timeout: hready stayed %b after %0d cycles", acc, n);
        end
        if (sel && tr[1] && track) predict(a, w, sz, wd);
        hwdata = wd;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) issue(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    endtask

    // Monitor: completes a data phase on the first cycle its responder shows hreadyout=1.
    initial begin
        logic [NDUT-1:0] pend;
        int   wc [NDUT];
        exp_t e;
        pend = '0;
        for (int i = 0; i < NDUT; i++) begin wc[i] = 0; rd_ptr[i] = 0; end
        forever begin
            @(negedge hclk);
            if (hreset) begin
                pend = '0;
                for (int i = 0; i < NDUT; i++) wc[i] = 0;
            end else begin
                for (int i = 0; i < NDUT; i++) begin
                    if (pend[i] && rd_ptr[i] < sbq.size()) begin
                        e = sbq[rd_ptr[i]];
                        if (!rdy[i]) begin
                            wc[i]++;
                            chk("stall_hresp", i, 32'(resp[i]), 32'(e.err));
                            chk("stall_hrdata", i, rdata[i], 32'h0);
                        end else begin
                            chk("hresp", i, 32'(resp[i]), 32'(e.err));
                            chk("hrdata", i, rdata[i], e.data);
                            chk("stall_cycles", i, wc[i], e.err ? 1 : ws_of(i));
                            rd_ptr[i]++;
                            pend[i] = 1'b0;
                            wc[i] = 0;
                        end
                    end
                    if (hsel && htrans[1] && hready) pend[i] = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", nerr);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge hclk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("rst_hreadyout", i, 32'(rdy[i]), 32'h1);
            chk("rst_hresp", i, 32'(resp[i]), 32'h0);
            chk("rst_hrdata", i, rdata[i], 32'h0);
        end
        hreset = 1'b0;
        idle(1);

        // Known contents for every word the random phase may read.
        for (int w = 0; w < 64; w++) issue(1'b1, 2'b10, 32'(w * 4), 1'b1, 3'd2, $urandom);
        issue(1'b1, 2'b10, MEM_BYTES - 4, 1'b1, 3'd2, 32'h0BAD_F00D);
        issue(1'b1, 2'b10, MEM_BYTES - 4, 1'b0, 3'd2, 32'h0);

        issue(1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
        issue(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0);
        issue(1'b1, 2'b10, 32'h13, 1'b1, 3'd0, 32'hA500_0000);
        issue(1'b1, 2'b11, 32'h10, 1'b1, 3'd1, 32'h0000_1234);
        issue(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0);
        issue(1'b1, 2'b10, 32'h14, 1'b0, 3'd2, 32'h0);
        issue(1'b1, 2'b11, 32'h18, 1'b0, 3'd2, 32'h0);
        issue(1'b1, 2'b11, 32'h1C, 1'b1, 3'd2, 32'h5555_AAAA);
        issue(1'b1, 2'b10, 32'h20, 1'b1, 3'd2, 32'hCAFE_F00D);
        issue(1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 32'h0);
        issue(1'b1, 2'b10, MEM_BYTES, 1'b0, 3'd2, 32'h0);
        issue(1'b1, 2'b10, 32'h01, 1'b1, 3'd1, 32'hFFFF_FFFF);
        issue(1'b1, 2'b10, 32'h00, 1'b1, 3'd3, 32'hFFFF_FFFF);
        issue(1'b1, 2'b10, 32'h00, 1'b0, 3'd2, 32'h0);

        for (int k = 0; k < 300; k++) begin
            int unsigned r, kind;
            logic [2:0]  sz;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            if (r < 12) begin
                issue(1'($urandom), (r < 6) ? 2'b00 : 2'b01, $urandom, 1'($urandom), 3'd2, $urandom);
            end else if (r < 16) begin
                issue(1'b0, 2'b10, $urandom_range(0, 255), 1'($urandom), 3'd0, $urandom);
            end else if (r < 28) begin
                kind = $urandom_range(0, 3);
                sz = 3'($urandom_range(0, 2));
                a = 32'($urandom_range(0, 255));
                case (kind)
                    0: a = MEM_BYTES + 32'($urandom_range(0, 4000));
                    1: begin sz = 3'd1; a = a | 32'h1; end
                    2: begin sz = 3'd2; a = (a & ~32'h3) | 32'($urandom_range(1, 3)); end
                    default: sz = 3'($urandom_range(3, 7));
                endcase
                issue(1'b1, 2'b10, a, 1'($urandom), sz, $urandom);
            end else begin
                sz = 3'($urandom_range(0, 2));
                a = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 1);
                issue(1'b1, 2'($urandom_range(2, 3)), a, 1'($urandom), sz, $urandom);
            end
        end
        idle(2);

        // Reset lands while the write to 0x40 is in its first data-phase cycle.
        issue(1'b1, 2'b10, 32'h40, 1'b1, 3'd2, 32'h1111_1111, 1'b0);
        hreset = 1'b1;
        hsel = 1'b0;
        htrans = 2'b00;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            chk("midrst_hreadyout", i, 32'(rdy[i]), 32'h1);
            chk("midrst_hresp", i, 32'(resp[i]), 32'h0);
            chk("midrst_hrdata", i, rdata[i], 32'h0);
        end
        issue(1'b1, 2'b01, 32'h40, 1'b1, 3'd2, 32'h0);
        issue(1'b1, 2'b00, 32'h40, 1'b1, 3'd2, 32'h0);
        for (int i = 0; i < NDUT; i++) begin
            chk("idle_hreadyout", i, 32'(rdy[i]), 32'h1);
            chk("idle_hresp", i, 32'(resp[i]), 32'h0);
        end
        issue(1'b1, 2'b10, 32'h40, 1'b0, 3'd2, 32'h0);
        idle(6);

        for (int i = 0; i < NDUT; i++) chk("drained", i, 32'(rd_ptr[i]), 32'(sbq.size()));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder (slave end of the AHB bus) backed by a word-addressed register-array memory.
- Accepts single and burst transfers from the bus fabric and supports byte, halfword and word writes.
- Inserts a parameterised number of wait states per transfer.
- Returns a two-cycle ERROR response for out-of-range, misaligned or oversized accesses.

Parameters:
- AHB_ADDR_WIDTH, 32: haddr width.
- AHB_DATA_WIDTH, 32: hwdata/hrdata width; fixed at 32 for this block.
- MEM_DEPTH, 1024: number of 32-bit words; valid byte range is 0 .. MEM_DEPTH*4-1.
- WAIT_STATES, 0: extra cycles (hreadyout=0) per OKAY data phase; legal range 0..15.

Ports:
- hclk  input  1  bus clock; everything is sampled on its rising edge.
- hreset  input  1  synchronous active-high reset.
- hsel  input  1  slave select from decoder.
- haddr  input  AHB_ADDR_WIDTH  address-phase byte address.
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  input  1  1=write.
- hsize  input  3  0=byte, 1=half, 2=word; values of 3 or more are illegal.
- hburst  input  3  accepted and ignored; each beat is decoded independently.
- hprot  input  4  ignored.
- hmastlock  input  1  ignored.
- hready  input  1  bus-level ready; the previous transfer is complete.
- hwdata  input  AHB_DATA_WIDTH  write data, valid in the data phase.
- hrdata  output  AHB_DATA_WIDTH  read data.
- hreadyout  output  1  slave ready.
- hresp  output  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, all captured phase registers cleared. Memory contents are not reset.
- Reset asserted mid-transfer (wait or error state) abandons the transfer. No memory write occurs in that cycle.
- Address-phase accept when hsel & hready & htrans[1]. IDLE and BUSY (htrans[1]=0), or hsel=0, produce no data phase, so the next data phase is zero-wait OKAY.
- On accept, capture: addr_q=haddr, write_q, size_q, and err_q.
- err_q is set if any of: haddr >= MEM_DEPTH*4; hsize>2; hsize=1 & haddr[0]; hsize=2 & haddr[1:0]!=0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0. Accept with err_q → ERR1; accept with WAIT_STATES>0 → WAIT (counter=WAIT_STATES-1); accept with WAIT_STATES=0 → DATA.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; at 0 → DATA.
  - DATA: hreadyout=1, hresp=0; the transfer completes this cycle. A new accept in the same cycle follows the IDLE rules (back-to-back pipelining); otherwise → IDLE.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1. Next state per the IDLE rules, which allows a new accept.
  - In ERR1 the master may drive htrans=IDLE; no special handling is required.
- No accept occurs while hready=0; the slave never samples the address phase during its own wait or ERR1 cycles.
- Write commit: at the rising edge ending DATA with write_q=1. Lanes use little-endian byte strobes:
  - byte: lane addr_q[1:0];
  - half: lanes {addr_q[1],0}..+1;
  - word: all 4 lanes.
  - Unselected bytes are unchanged; errored writes never modify memory.
- Read data: hrdata = mem[addr_q[.. :2]] combinationally, only while in DATA with write_q=0; otherwise hrdata=0.
  - Full word is driven regardless of size; the master selects lanes.
  - A write in DATA followed immediately by a read of the same word returns the new data, because the write commits before the read's DATA cycle.
- hrdata in WAIT states: 0 (not valid until hreadyout=1).

Test Plan:
- Word write 0x0000_0010 ← 0xDEADBEEF then NONSEQ read (WAIT_STATES=0) → write DATA hreadyout=1 hresp=0; read DATA hrdata=0xDEADBEEF, single-cycle data phases.
- Byte write 0xA5 to 0x13, half write 0x1234 to 0x10, over word 0xDEADBEEF at 0x10 → read 0x10 returns 0xA5AD1234.
- WAIT_STATES=2, back-to-back read/read/write → each data phase shows exactly 2 cycles hreadyout=0 then 1; address phases are held by the master and accepted once each.
- Write 0xCAFEF00D at 0x20 immediately followed by read 0x20 (pipelined) → read returns 0xCAFEF00D.
- Access haddr=MEM_DEPTH*4, then half at 0x01, then hsize=3 → each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); memory is unchanged; a following valid read is OKAY.
- hreset asserted in WAIT of a write (WAIT_STATES=3), data 0x11111111 to 0x40 → next cycle hreadyout=1, hresp=0, hrdata=0; 0x40 keeps its prior value; IDLE/BUSY cycles give OKAY zero-wait.
